// File: rtl/my_demux_stream_pkg.sv
// Shared definitions for the my_demux_stream stream demultiplexer.
// Holds the packet-routing FSM state encoding used by the top level.
package my_demux_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

endpackage

// File: rtl/my_demux_stream_out_slice.sv
// demux_out_slice: one-entry valid/ready register for one output channel.
// Ports: clk, rst (sync, active-high), load_i/data_i/last_i (beat routed here),
//        ready_i (consumer ready), valid_o/data_o/last_o (registered beat).
module demux_out_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // A load wins over a drain: the new beat replaces the departing one.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/my_demux_stream.sv
// my_demux_stream: routes each packet of one valid/ready stream to the output
// channel named by s_sel on its first beat; out-of-range packets are dropped.
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_data/s_sel/s_last
//        input stream; m_valid/m_ready/m_data/m_last per-channel outputs
//        (m_data flattened, channel k at [k*WIDTH +: WIDTH]);
//        drop_pulse/drop_cnt report dropped packets.
module my_demux_stream
    import my_demux_stream_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    input  logic [SEL_W-1:0]         s_sel,
    input  logic                     s_last,
    output logic [NUM_OUT-1:0]       m_valid,
    input  logic [NUM_OUT-1:0]       m_ready,
    output logic [NUM_OUT*WIDTH-1:0] m_data,
    output logic [NUM_OUT-1:0]       m_last,
    output logic                     drop_pulse,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int NSEL = 2 ** SEL_W;
    localparam logic [SEL_W:0] NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   dest_q, dest_d;
    logic               drop_pulse_q, drop_pulse_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [SEL_W-1:0]   target;
    logic [NSEL-1:0]    slot_free;
    logic               sel_bad;
    logic               discard;
    logic               accept;
    logic [NUM_OUT-1:0] load;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dest_q       <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            dest_q       <= dest_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Output / datapath decode. slot_free is padded to the full select
    // range so an unused select value never indexes past the channel set.
    always_comb begin
        target    = (state_q == ST_IDLE) ? s_sel : dest_q;
        sel_bad   = (state_q == ST_IDLE) && ({1'b0, s_sel} >= NUM_OUT_V);
        discard   = (state_q == ST_DROP) || sel_bad;
        slot_free = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            slot_free[k] = !m_valid[k] || m_ready[k];
        end
        s_ready = discard || slot_free[target];
        accept  = s_valid && s_ready;
        load    = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            load[k] = accept && !discard && (target == SEL_W'(k));
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !s_last) begin
                    if (sel_bad) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_ROUTE;
                        dest_d  = s_sel;
                    end
                end
            end
            ST_ROUTE: begin
                if (accept && s_last) state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (accept && s_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drop accounting: only a packet's first beat can be flagged sel_bad.
    always_comb begin
        drop_pulse_d = accept && sel_bad;
        drop_cnt_d   = drop_cnt_q;
        if (drop_pulse_d && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slice
        demux_out_slice #(
            .WIDTH(WIDTH)
        ) u_slice (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[k]),
            .data_i (s_data),
            .last_i (s_last),
            .ready_i(m_ready[k]),
            .valid_o(m_valid[k]),
            .data_o (m_data[k*WIDTH +: WIDTH]),
            .last_o (m_last[k])
        );
    end

endmodule

// File: tb/tb_my_demux_stream.sv
// Testbench for my_demux_stream (3 channels, 2-bit select, 8-bit counter).
// Packet-level model feeds per-channel scoreboards drained by a monitor.
module tb_my_demux_stream;

    localparam int W  = 8;
    localparam int NO = 3;

    logic            clk;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic [1:0]      s_sel;
    logic            s_last;
    logic [NO-1:0]   m_valid;
    logic [NO-1:0]   m_ready;
    logic [NO*W-1:0] m_data;
    logic [NO-1:0]   m_last;
    logic            drop_pulse;
    logic [7:0]      drop_cnt;

    my_demux_stream #(
        .WIDTH(W), .NUM_OUT(NO), .SEL_W(2), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sel(s_sel), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {last, data}
    logic [W:0] sbq[NO][$];

    // Packet-level reference state
    bit         in_pkt;
    bit         in_drop;
    int         pkt_dest;
    bit         exp_pulse;
    int         exp_cnt;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        in_pkt    = 0;
        in_drop   = 0;
        pkt_dest  = 0;
        exp_pulse = 0;
        exp_cnt   = 0;
        for (int k = 0; k < NO; k++) sbq[k].delete();
    endtask

    task automatic model_beat();
        if (in_pkt) begin
            sbq[pkt_dest].push_back({s_last, s_data});
            if (s_last) in_pkt = 0;
        end else if (in_drop) begin
            if (s_last) in_drop = 0;
        end else if (int'(s_sel) >= NO) begin
            exp_pulse = 1;
            exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (!s_last) in_drop = 1;
        end else begin
            sbq[s_sel].push_back({s_last, s_data});
            if (!s_last) begin
                in_pkt   = 1;
                pkt_dest = int'(s_sel);
            end
        end
    endtask

    // One cycle: inputs already driven at this negedge.
    task automatic step(output bit acc);
        bit forced;
        #2;
        acc = 0;
        if (rst) begin
            model_reset();
        end else begin
            chk("drop_pulse", 32'(drop_pulse), 32'(exp_pulse));
            chk("drop_cnt", 32'(drop_cnt), 32'(exp_cnt));
            exp_pulse = 0;
            forced = in_drop || (!in_pkt && int'(s_sel) >= NO);
            if (s_valid && forced) chk("s_ready_forced", 32'(s_ready), 32'd1);
            acc = s_valid && s_ready;
            if (acc) model_beat();
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        bit a;
        s_valid = 0;
        repeat (n) step(a);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] sel,
                        input logic last, output int cyc);
        bit a;
        s_valid = 1;
        s_data  = d;
        s_sel   = sel;
        s_last  = last;
        cyc = 0;
        do begin
            step(a);
            cyc++;
        end while (!a && cyc < 50);
        if (!a) begin
            errors++;
            $display("FAIL send_timeout got=stalled want=accepted");
        end
        s_valid = 0;
    endtask

    task automatic drain_check();
        m_ready = '1;
        idle(4);
        for (int k = 0; k < NO; k++) chk("sb_empty", 32'(sbq[k].size()), 32'd0);
    endtask

    // Monitor: compares every output handshake with the scoreboard.
    always begin
        logic [W:0] exp;
        @(negedge clk);
        #2;
        if (!rst) begin
            for (int k = 0; k < NO; k++) begin
                if (m_valid[k] && m_ready[k]) begin
                    checks++;
                    if (sbq[k].size() == 0) begin
                        errors++;
                        $display("FAIL ch%0d_extra got=%h want=none",
                                 k, {m_last[k], m_data[k*W +: W]});
                    end else begin
                        exp = sbq[k].pop_front();
                        if ({m_last[k], m_data[k*W +: W]} !== exp) begin
                            errors++;
                            $display("FAIL ch%0d_beat got=%h want=%h",
                                     k, {m_last[k], m_data[k*W +: W]}, exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit a;
        int cyc;
        rst     = 1;
        s_valid = 0;
        s_data  = '0;
        s_sel   = '0;
        s_last  = 0;
        m_ready = '1;
        model_reset();
        @(negedge clk);
        idle(2);
        rst = 0;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // single-beat packet to channel 2
        send(8'hA5, 2'd2, 1'b1, cyc);
        chk("t1_m_valid", 32'(m_valid), 32'b100);
        chk("t1_m_data", 32'(m_data[23:16]), 32'hA5);
        chk("t1_m_last", 32'(m_last[2]), 32'd1);
        idle(1);

        // 3-beat packet, select changes mid-packet are ignored
        send(8'h11, 2'd1, 1'b0, cyc);
        chk("t2_rate", 32'(cyc), 32'd1);
        send(8'h22, 2'd3, 1'b0, cyc);
        chk("t2_rate", 32'(cyc), 32'd1);
        send(8'h33, 2'd3, 1'b1, cyc);
        chk("t2_rate", 32'(cyc), 32'd1);
        chk("t2_route", 32'(m_valid), 32'b010);
        drain_check();

        // backpressure on channel 1
        m_ready = 3'b101;
        send(8'h44, 2'd1, 1'b0, cyc);
        s_valid = 1;
        s_data  = 8'h55;
        repeat (3) begin
            step(a);
            chk("t3_stall", 32'(a), 32'd0);
        end
        m_ready = '1;
        send(8'h55, 2'd1, 1'b0, cyc);
        chk("t3_resume", 32'(cyc), 32'd1);
        send(8'h66, 2'd1, 1'b1, cyc);
        chk("t3_rate", 32'(cyc), 32'd1);
        drain_check();

        // reset mid-packet
        m_ready = 3'b110;
        send(8'h77, 2'd0, 1'b0, cyc);
        chk("t5_held", 32'(m_valid[0]), 32'd1);
        rst     = 1;
        s_valid = 1;
        s_data  = 8'h88;
        step(a);
        rst     = 0;
        s_valid = 0;
        chk("t5_cleared", 32'(m_valid), 32'd0);
        m_ready = '1;
        send(8'h99, 2'd2, 1'b1, cyc);
        chk("t5_newsel", 32'(m_valid), 32'b100);
        drain_check();

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = W'($urandom);
            s_sel   = 2'($urandom_range(0, 3));
            s_last  = ($urandom_range(0, 3) == 0);
            m_ready = NO'($urandom);
            step(a);
        end
        drain_check();

        // drop counter saturation
        rst = 1;
        idle(1);
        rst = 0;
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom), 2'd3, 1'b0, cyc);
            if (i == 0) begin
                chk("t4_pulse", 32'(drop_pulse), 32'd1);
                chk("t4_cnt", 32'(drop_cnt), 32'd1);
            end
            send(8'($urandom), 2'($urandom), 1'b1, cyc);
            if (i == 0) chk("t4_pulse_once", 32'(drop_pulse), 32'd0);
        end
        idle(2);
        chk("t4_sat", 32'(drop_cnt), 32'd255);
        drain_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
